// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS-subset core:
// opcode/funct encodings, CP0 register numbers, exception codes, ALU ops.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] FETCH_LO       = 32'h0000_3000;
  localparam logic [31:0] FETCH_HI       = 32'h0000_6FFC;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0]  COP0_MF   = 5'h00;
  localparam logic [4:0]  COP0_MT   = 5'h04;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} mem_size_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK, WB_CP0} wb_sel_t;

endpackage

// File: rtl/cp0.sv
// Minimal coprocessor 0: SR/Cause/EPC, interrupt request, exception entry and eret.
module cp0
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_interrupt,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_exc,
  input  logic [4:0]  i_exc_code,
  input  logic [31:0] i_pc,
  input  logic        i_eret,
  output logic [31:0] o_rdata,
  output logic [31:0] o_epc,
  output logic        o_irq
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  // IP is a live view of the pin; only line 12 is wired.
  assign w_cause = {16'b0, 3'b0, i_interrupt, 2'b0, 3'b0, r_exccode, 2'b0};
  assign o_irq   = i_interrupt & r_im[2] & r_ie & ~r_exl;
  assign o_epc   = r_epc;

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CP0_SR:    o_rdata = w_sr;
      CP0_CAUSE: o_rdata = w_cause;
      CP0_EPC:   o_rdata = r_epc;
      default:   o_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else if (i_exc) begin
      r_epc     <= i_pc;
      r_exccode <= i_exc_code;
      r_exl     <= 1'b1;
    end else if (i_eret) begin
      r_exl <= 1'b0;
    end else if (i_we) begin
      if (i_addr == CP0_SR) begin
        r_im  <= i_wdata[15:10];
        r_exl <= i_wdata[1];
        r_ie  <= i_wdata[0];
      end else if (i_addr == CP0_EPC) begin
        r_epc <= i_wdata;
      end
    end
  end

endmodule

// File: rtl/mips.sv
// Single-cycle MIPS-subset core: inline GRF, decoder and ALU; CP0 as a submodule.
module mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] macroscopic_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  logic [31:0] r_pc;
  logic [31:0] r_grf [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_rs_val, w_rt_val, w_sext, w_ext, w_b, w_alu_y, w_pc4, w_npc;
  logic [31:0] w_load_data, w_cp0_rdata, w_epc;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [3:0]  w_be;
  logic [4:0]  w_exc_code;
  logic        w_ri, w_regwe, w_use_imm, w_zext, w_load, w_store, w_beq, w_bne;
  logic        w_jump, w_jr, w_mtc0, w_eret, w_taken, w_mis, w_irq, w_fetch_bad, w_exc;
  alu_op_t     w_alu;
  mem_size_t   w_size;
  wb_sel_t     w_wb;

  assign w_op     = i_inst_rdata[31:26];
  assign w_rs     = i_inst_rdata[25:21];
  assign w_rt     = i_inst_rdata[20:16];
  assign w_rd     = i_inst_rdata[15:11];
  assign w_funct  = i_inst_rdata[5:0];
  assign w_imm    = i_inst_rdata[15:0];
  assign w_rs_val = r_grf[w_rs];
  assign w_rt_val = r_grf[w_rt];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_ext    = w_zext ? {16'b0, w_imm} : w_sext;
  assign w_b      = w_use_imm ? w_ext : w_rt_val;
  assign w_pc4    = r_pc + 32'd4;

  always_comb begin
    w_ri = 1'b0; w_regwe = 1'b0; w_grf_addr = w_rd; w_alu = ALU_ADD;
    w_use_imm = 1'b0; w_zext = 1'b0; w_load = 1'b0; w_store = 1'b0;
    w_size = SZ_WORD; w_wb = WB_ALU; w_beq = 1'b0; w_bne = 1'b0;
    w_jump = 1'b0; w_jr = 1'b0; w_mtc0 = 1'b0; w_eret = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_regwe = 1'b1;
        case (w_funct)
          FN_ADDU: w_alu = ALU_ADD;
          FN_SUBU: w_alu = ALU_SUB;
          FN_AND:  w_alu = ALU_AND;
          FN_OR:   w_alu = ALU_OR;
          FN_SLT:  w_alu = ALU_SLT;
          FN_JR:   begin w_regwe = 1'b0; w_jr = 1'b1; end
          FN_SLL:  begin w_regwe = 1'b0; w_ri = (i_inst_rdata != '0); end
          default: begin w_regwe = 1'b0; w_ri = 1'b1; end
        endcase
      end
      OP_ORI:   begin w_regwe = 1'b1; w_grf_addr = w_rt; w_use_imm = 1'b1; w_zext = 1'b1; w_alu = ALU_OR; end
      OP_LUI:   begin w_regwe = 1'b1; w_grf_addr = w_rt; w_use_imm = 1'b1; w_alu = ALU_LUI; end
      OP_ADDIU: begin w_regwe = 1'b1; w_grf_addr = w_rt; w_use_imm = 1'b1; end
      OP_LW, OP_LH, OP_LB: begin
        w_regwe = 1'b1; w_grf_addr = w_rt; w_use_imm = 1'b1; w_load = 1'b1; w_wb = WB_MEM;
        w_size = (w_op == OP_LW) ? SZ_WORD : (w_op == OP_LH) ? SZ_HALF : SZ_BYTE;
      end
      OP_SW, OP_SH, OP_SB: begin
        w_use_imm = 1'b1; w_store = 1'b1;
        w_size = (w_op == OP_SW) ? SZ_WORD : (w_op == OP_SH) ? SZ_HALF : SZ_BYTE;
      end
      OP_BEQ: w_beq = 1'b1;
      OP_BNE: w_bne = 1'b1;
      OP_J:   w_jump = 1'b1;
      OP_JAL: begin w_jump = 1'b1; w_regwe = 1'b1; w_grf_addr = 5'd31; w_wb = WB_LINK; end
      OP_COP0: begin
        if (w_rs == COP0_MF) begin
          w_regwe = 1'b1; w_grf_addr = w_rt; w_wb = WB_CP0;
        end else if (w_rs == COP0_MT) begin
          w_mtc0 = 1'b1;
        end else if (i_inst_rdata == ERET_WORD) begin
          w_eret = 1'b1;
        end else begin
          w_ri = 1'b1;
        end
      end
      default: w_ri = 1'b1;
    endcase
  end

  always_comb begin
    case (w_alu)
      ALU_ADD: w_alu_y = w_rs_val + w_b;
      ALU_SUB: w_alu_y = w_rs_val - w_b;
      ALU_AND: w_alu_y = w_rs_val & w_b;
      ALU_OR:  w_alu_y = w_rs_val | w_b;
      ALU_SLT: w_alu_y = {31'b0, $signed(w_rs_val) < $signed(w_b)};
      ALU_LUI: w_alu_y = {w_imm, 16'b0};
      default: w_alu_y = '0;
    endcase
  end

  assign m_data_addr = w_alu_y;
  assign w_half      = m_data_addr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
  assign w_byte      = m_data_rdata[8*m_data_addr[1:0] +: 8];

  always_comb begin
    w_be = 4'b1111;
    m_data_wdata = w_rt_val;
    w_load_data = m_data_rdata;
    w_mis = (m_data_addr[1:0] != 2'b00);
    case (w_size)
      SZ_HALF: begin
        w_be = m_data_addr[1] ? 4'b1100 : 4'b0011;
        m_data_wdata = {2{w_rt_val[15:0]}};
        w_load_data = {{16{w_half[15]}}, w_half};
        w_mis = m_data_addr[0];
      end
      SZ_BYTE: begin
        w_be = 4'b0001 << m_data_addr[1:0];
        m_data_wdata = {4{w_rt_val[7:0]}};
        w_load_data = {{24{w_byte[7]}}, w_byte};
        w_mis = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_fetch_bad = (r_pc[1:0] != 2'b00) || (r_pc < FETCH_LO) || (r_pc > FETCH_HI);
  assign w_exc = w_irq | w_fetch_bad | w_ri | ((w_load | w_store) & w_mis);

  always_comb begin
    if (w_irq)            w_exc_code = EXC_INT;
    else if (w_fetch_bad) w_exc_code = EXC_ADEL;
    else if (w_ri)        w_exc_code = EXC_RI;
    else if (w_load)      w_exc_code = EXC_ADEL;
    else                  w_exc_code = EXC_ADES;
  end

  always_comb begin
    case (w_wb)
      WB_MEM:  w_grf_wdata = w_load_data;
      WB_LINK: w_grf_wdata = w_pc4;
      WB_CP0:  w_grf_wdata = w_cp0_rdata;
      default: w_grf_wdata = w_alu_y;
    endcase
  end

  assign w_taken = (w_beq & (w_rs_val == w_rt_val)) | (w_bne & (w_rs_val != w_rt_val));

  always_comb begin
    w_npc = w_pc4;
    if (w_exc)        w_npc = HANDLER_PC;
    else if (w_eret)  w_npc = w_epc;
    else if (w_jr)    w_npc = w_rs_val;
    else if (w_jump)  w_npc = {r_pc[31:28], i_inst_rdata[25:0], 2'b00};
    else if (w_taken) w_npc = w_pc4 + {w_sext[29:0], 2'b00};
  end

  assign w_grf_we       = w_regwe & ~w_exc & ~reset;
  assign m_data_byteen  = (w_store & ~w_exc & ~reset) ? w_be : 4'b0000;
  assign macroscopic_pc = r_pc;
  assign i_inst_addr    = r_pc;
  assign m_inst_addr    = r_pc;
  assign w_inst_addr    = r_pc;

  cp0 u_cp0 (
    .clk        (clk),
    .reset      (reset),
    .i_interrupt(interrupt),
    .i_we       (w_mtc0 & ~w_exc),
    .i_addr     (w_rd),
    .i_wdata    (w_rt_val),
    .i_exc      (w_exc),
    .i_exc_code (w_exc_code),
    .i_pc       (r_pc),
    .i_eret     (w_eret & ~w_exc),
    .o_rdata    (w_cp0_rdata),
    .o_epc      (w_epc),
    .o_irq      (w_irq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      for (int unsigned i = 0; i < 32; i++) r_grf[i] <= '0;
    end else begin
      r_pc <= w_npc;
      if (w_grf_we && (w_grf_addr != 5'd0)) r_grf[w_grf_addr] <= w_grf_wdata;
    end
  end

endmodule

// File: tb/tb_mips.sv
// Directed program run against mips with a per-cycle table of expected bus/GRF activity.
module tb_mips;

  logic        clk = 1'b0;
  logic        reset, interrupt;
  logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata;
  logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  logic [31:0] imem [0:4095];
  logic [31:0] dmem [0:1023];
  logic [31:0] w_off;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        intr;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] da;
    logic [31:0] dw;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mips #(.RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
    .w_inst_addr(w_inst_addr)
  );

  assign w_off = i_inst_addr - 32'h3000;
  assign i_inst_rdata = (i_inst_addr >= 32'h3000 && i_inst_addr < 32'h7000) ? imem[w_off[13:2]] : 32'h0;
  assign m_data_rdata = dmem[m_data_addr[11:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 32'h0;
      dmem[0] <= 32'h8001_0000;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b] && m_data_addr < 32'h1000)
          dmem[m_data_addr[11:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction
  function automatic logic [31:0] mfc0(input logic [4:0] rt, input logic [4:0] rd);
    return {6'h10, 5'h00, rt, rd, 11'h0};
  endfunction
  function automatic logic [31:0] mtc0(input logic [4:0] rt, input logic [4:0] rd);
    return {6'h10, 5'h04, rt, rd, 11'h0};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] o;
    o = addr - 32'h3000;
    imem[o[13:2]] = word;
  endtask

  task automatic v_wr(input logic intr, input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    vecs.push_back('{intr, pc, 1'b1, wa, wd, 4'b0000, 32'h0, 32'h0});
  endtask
  task automatic v_none(input logic intr, input logic [31:0] pc);
    vecs.push_back('{intr, pc, 1'b0, 5'd0, 32'h0, 4'b0000, 32'h0, 32'h0});
  endtask
  task automatic v_st(input logic [31:0] pc, input logic [3:0] be, input logic [31:0] da, input logic [31:0] dw);
    vecs.push_back('{1'b0, pc, 1'b0, 5'd0, 32'h0, be, da, dw});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    ok = (macroscopic_pc === v.pc) && (i_inst_addr === v.pc) && (m_inst_addr === v.pc) &&
         (w_inst_addr === v.pc) && (w_grf_we === v.we) && (m_data_byteen === v.be);
    if (v.we) ok = ok && (w_grf_addr === v.wa) && (w_grf_wdata === v.wd);
    if (v.be != 4'b0000) ok = ok && (m_data_addr === v.da) && (m_data_wdata === v.dw);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got pc=%h we=%b a=%0d d=%h be=%b da=%h dw=%h; want pc=%h we=%b a=%0d d=%h be=%b da=%h dw=%h",
               idx, macroscopic_pc, w_grf_we, w_grf_addr, w_grf_wdata, m_data_byteen, m_data_addr, m_data_wdata,
               v.pc, v.we, v.wa, v.wd, v.be, v.da, v.dw);
    end
  endtask

  // Handler: non-interrupt causes skip the faulting instruction, then ack and eret.
  task automatic handler_vecs(input logic intr0, input logic [31:0] cause, input logic [31:0] code4,
                              input logic [31:0] epc);
    v_wr(intr0, 32'h4180, 5'd26, cause);
    v_wr(1'b0, 32'h4184, 5'd27, 32'h7C);
    v_wr(1'b0, 32'h4188, 5'd26, code4);
    v_none(1'b0, 32'h418C);
    if (code4 != 32'h0) begin
      v_wr(1'b0, 32'h4190, 5'd27, epc);
      v_wr(1'b0, 32'h4194, 5'd27, epc + 32'd4);
      v_none(1'b0, 32'h4198);
    end
    v_st(32'h419C, 4'b1111, 32'h7F20, 32'h0);
    v_none(1'b0, 32'h41A0);
  endtask

  initial begin
    reset = 1'b1;
    interrupt = 1'b0;
    for (int i = 0; i < 4096; i++) imem[i] = 32'h0;

    put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    put(32'h3004, 32'hFC00_0000);
    put(32'h3008, enc_i(6'h0D, 5'd0, 5'd4, 16'h1001));
    put(32'h300C, mtc0(5'd4, 5'd12));
    put(32'h3010, enc_i(6'h0D, 5'd0, 5'd2, 16'h00AB));
    put(32'h3014, enc_i(6'h28, 5'd0, 5'd2, 16'h0001));
    put(32'h3018, enc_i(6'h2B, 5'd0, 5'd1, 16'h0008));
    put(32'h301C, enc_i(6'h21, 5'd0, 5'd3, 16'h0002));
    put(32'h3020, enc_i(6'h23, 5'd0, 5'd5, 16'h0002));
    put(32'h3024, enc_i(6'h23, 5'd0, 5'd6, 16'h0008));
    put(32'h3028, mfc0(5'd7, 5'd13));
    put(32'h302C, mfc0(5'd8, 5'd14));
    put(32'h3030, mfc0(5'd9, 5'd12));
    put(32'h3034, enc_j(6'h03, 32'h3040));
    put(32'h3038, enc_i(6'h09, 5'd0, 5'd14, 16'hFFFF));
    put(32'h303C, enc_j(6'h02, 32'h3060));
    put(32'h3040, enc_r(5'd1, 5'd2, 5'd10, 6'h23));
    put(32'h3044, enc_r(5'd3, 5'd1, 5'd11, 6'h2A));
    put(32'h3048, enc_i(6'h0F, 5'd0, 5'd12, 16'h8000));
    put(32'h304C, enc_r(5'd12, 5'd12, 5'd13, 6'h21));
    put(32'h3050, enc_i(6'h05, 5'd13, 5'd0, 16'h0005));
    put(32'h3054, enc_i(6'h04, 5'd0, 5'd0, 16'h0001));
    put(32'h3058, enc_i(6'h0D, 5'd0, 5'd14, 16'h5555));
    put(32'h305C, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    put(32'h3060, enc_i(6'h29, 5'd0, 5'd2, 16'h0006));
    put(32'h3064, enc_i(6'h20, 5'd0, 5'd15, 16'h0001));
    put(32'h3068, enc_i(6'h0D, 5'd0, 5'd0, 16'h0005));
    put(32'h306C, enc_r(5'd0, 5'd0, 5'd16, 6'h25));
    put(32'h3070, 32'h0000_0000);
    put(32'h3074, enc_i(6'h2B, 5'd0, 5'd1, 16'h000C));
    put(32'h4180, mfc0(5'd26, 5'd13));
    put(32'h4184, enc_i(6'h0D, 5'd0, 5'd27, 16'h007C));
    put(32'h4188, enc_r(5'd26, 5'd27, 5'd26, 6'h24));
    put(32'h418C, enc_i(6'h04, 5'd26, 5'd0, 16'h0003));
    put(32'h4190, mfc0(5'd27, 5'd14));
    put(32'h4194, enc_i(6'h09, 5'd27, 5'd27, 16'h0004));
    put(32'h4198, mtc0(5'd27, 5'd14));
    put(32'h419C, enc_i(6'h2B, 5'd0, 5'd0, 16'h7F20));
    put(32'h41A0, 32'h4200_0018);

    v_wr(1'b0, 32'h3000, 5'd1, 32'h0000_1234);
    v_none(1'b0, 32'h3004);
    handler_vecs(1'b0, 32'h28, 32'h28, 32'h3004);
    v_wr(1'b0, 32'h3008, 5'd4, 32'h0000_1001);
    v_none(1'b0, 32'h300C);
    v_wr(1'b0, 32'h3010, 5'd2, 32'h0000_00AB);
    v_st(32'h3014, 4'b0010, 32'h1, 32'hABAB_ABAB);
    v_none(1'b1, 32'h3018);
    handler_vecs(1'b1, 32'h1000, 32'h0, 32'h3018);
    v_st(32'h3018, 4'b1111, 32'h8, 32'h0000_1234);
    v_wr(1'b0, 32'h301C, 5'd3, 32'hFFFF_8001);
    v_none(1'b0, 32'h3020);
    handler_vecs(1'b0, 32'h10, 32'h10, 32'h3020);
    v_wr(1'b0, 32'h3024, 5'd6, 32'h0000_1234);
    v_wr(1'b0, 32'h3028, 5'd7, 32'h0000_0010);
    v_wr(1'b0, 32'h302C, 5'd8, 32'h0000_3024);
    v_wr(1'b0, 32'h3030, 5'd9, 32'h0000_1001);
    v_wr(1'b0, 32'h3034, 5'd31, 32'h0000_3038);
    v_wr(1'b0, 32'h3040, 5'd10, 32'h0000_1189);
    v_wr(1'b0, 32'h3044, 5'd11, 32'h0000_0001);
    v_wr(1'b0, 32'h3048, 5'd12, 32'h8000_0000);
    v_wr(1'b0, 32'h304C, 5'd13, 32'h0000_0000);
    v_none(1'b0, 32'h3050);
    v_none(1'b0, 32'h3054);
    v_none(1'b0, 32'h305C);
    v_wr(1'b0, 32'h3038, 5'd14, 32'hFFFF_FFFF);
    v_none(1'b0, 32'h303C);
    v_st(32'h3060, 4'b1100, 32'h6, 32'h00AB_00AB);
    v_wr(1'b0, 32'h3064, 5'd15, 32'hFFFF_FFAB);
    v_wr(1'b0, 32'h3068, 5'd0, 32'h0000_0005);
    v_wr(1'b0, 32'h306C, 5'd16, 32'h0000_0000);
    v_none(1'b0, 32'h3070);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_pc", macroscopic_pc, 32'h3000);
    chk("reset_we", {31'b0, w_grf_we}, 32'h0);
    chk("reset_byteen", {28'b0, m_data_byteen}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      interrupt = vecs[i].intr;
      #1;
      check_vec(i, vecs[i]);
      @(negedge clk);
    end

    // Mid-run reset with a pending interrupt and a store in flight.
    reset = 1'b1;
    interrupt = 1'b1;
    #1;
    chk("midreset_pc", macroscopic_pc, 32'h3074);
    chk("midreset_we", {31'b0, w_grf_we}, 32'h0);
    chk("midreset_byteen", {28'b0, m_data_byteen}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postreset_pc", macroscopic_pc, 32'h3000);
    chk("postreset_we", {31'b0, w_grf_we}, 32'h1);
    chk("postreset_wdata", w_grf_wdata, 32'h0000_1234);
    @(negedge clk);
    #1;
    chk("sr_cleared_no_irq", macroscopic_pc, 32'h3004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
